// File: rtl/reg_dump_sequencer.sv
// Walks the register file debug port over addresses 0..TAM-1 and streams each
// register MSB-first as bytes over a valid/ready interface to the UART TX.
module reg_dump_sequencer #(
  parameter int unsigned REGS = 5,
  parameter int unsigned NB   = 32,
  parameter int unsigned TAM  = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_abort,
  output logic [REGS-1:0] o_reg_debug_addr,
  input  logic [NB-1:0]   i_reg_debug_data,
  output logic            o_tx_valid,
  output logic [7:0]      o_tx_data,
  input  logic            i_tx_ready,
  output logic            o_busy,
  output logic            o_done
);

  localparam int unsigned NBYTES = NB / 8;
  localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_n;
  logic [REGS-1:0]   addr_q, addr_n;
  logic [NB-1:0]     shadow_q, shadow_n;
  logic [IW-1:0]     idx_q, idx_n;
  logic [7:0]        tx_byte_c;

  // State, counters and registered outputs; outputs are computed from next state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      shadow_q   <= '0;
      idx_q      <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_n;
      addr_q     <= addr_n;
      shadow_q   <= shadow_n;
      idx_q      <= idx_n;
      o_tx_valid <= (state_n == S_SEND);
      o_tx_data  <= (state_n == S_SEND) ? tx_byte_c : 8'h00;
      o_busy     <= (state_n != S_IDLE);
      o_done     <= (state_n == S_DONE);
    end
  end

  // Next-state and counter logic; abort overrides every transition
  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    shadow_n = shadow_q;
    idx_n    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_n  = '0;
          state_n = S_LATCH;
        end
      end
      S_LATCH: begin
        shadow_n = i_reg_debug_data;
        idx_n    = '0;
        state_n  = S_SEND;
      end
      S_SEND: begin
        if (o_tx_valid && i_tx_ready) begin
          if (idx_q != IW'(NBYTES - 1)) begin
            idx_n = idx_q + IW'(1);
          end else if (addr_q != REGS'(TAM - 1)) begin
            addr_n  = addr_q + REGS'(1);
            state_n = S_LATCH;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (i_abort && (state_q != S_IDLE)) begin
      state_n = S_IDLE;
    end
  end

  // Byte of the (next) shadow selected by the (next) index, MSB first
  always_comb begin
    tx_byte_c = 8'(shadow_n >> (8 * (int'(NBYTES) - 1 - int'(idx_n))));
  end

  assign o_reg_debug_addr = addr_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Directed bench for reg_dump_sequencer with a combinational register file model.
module tb_reg_dump_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_abort;
  logic [4:0]  o_reg_debug_addr;
  logic [31:0] i_reg_debug_data;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  logic [31:0] mem [32];
  logic [7:0]  byte_q [$];
  int compared = 0;
  int mismatched = 0;
  int cyc, done_cnt, done_cyc, busy_err, busy_end;
  logic s_valid, s_busy, s_done;
  logic [7:0] s_data;
  logic [4:0] s_addr;

  reg_dump_sequencer #(.REGS(5), .NB(32), .TAM(32)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .o_reg_debug_addr (o_reg_debug_addr),
    .i_reg_debug_data (i_reg_debug_data),
    .o_tx_valid       (o_tx_valid),
    .o_tx_data        (o_tx_data),
    .i_tx_ready       (i_tx_ready),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 i_clk = ~i_clk;

  always_comb i_reg_debug_data = mem[o_reg_debug_addr];

  // Expected byte j of a dump where mem[i] = i
  function automatic logic [7:0] exp_byte(input int j);
    logic [31:0] v;
    v = 32'(j / 4);
    return 8'(v >> (8 * (3 - (j % 4))));
  endfunction

  task automatic sample();
    @(negedge i_clk);
    cyc++;
    s_valid = o_tx_valid;
    s_data  = o_tx_data;
    s_busy  = o_busy;
    s_done  = o_done;
    s_addr  = o_reg_debug_addr;
    if (s_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_busy !== ((cyc >= 1 && cyc <= busy_end) ? 1'b1 : 1'b0)) busy_err++;
  endtask

  // Drive inputs for the coming edge; a byte is recorded when the handshake will complete
  task automatic drive(input logic rdy, input logic st, input logic ab);
    i_tx_ready = rdy;
    i_start    = st;
    i_abort    = ab;
    if (s_valid && rdy) byte_q.push_back(s_data);
  endtask

  task automatic start_dump();
    sample();
    drive(1'b1, 1'b1, 1'b0);
    cyc      = 0;
    done_cnt = 0;
    done_cyc = -1;
    busy_err = 0;
    byte_q.delete();
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_tx_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    compared++;
    if ({o_reg_debug_addr, o_tx_valid, o_tx_data, o_busy, o_done} !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got addr=%0d valid=%b data=%h busy=%b done=%b required all 0",
               o_reg_debug_addr, o_tx_valid, o_tx_data, o_busy, o_done);
    end
  endtask

  task automatic test_full_dump();
    busy_end = 161;
    start_dump();
    repeat (175) begin sample(); drive(1'b1, 1'b0, 1'b0); end
    compared++;
    if (byte_q.size() != 128) begin mismatched++; $display("FAIL full_count: got %0d required 128", byte_q.size()); end
    for (int j = 0; j < byte_q.size() && j < 128; j++) begin
      compared++;
      if (byte_q[j] !== exp_byte(j)) begin
        mismatched++; $display("FAIL full_byte[%0d]: got %h required %h", j, byte_q[j], exp_byte(j));
      end
    end
    compared++;
    if (done_cnt != 1 || done_cyc != 161) begin
      mismatched++; $display("FAIL full_done: got count=%0d cycle=%0d required count=1 cycle=161", done_cnt, done_cyc);
    end
    compared++;
    if (busy_err != 0) begin mismatched++; $display("FAIL full_busy: got %0d bad cycles required 0", busy_err); end
  endtask

  task automatic test_backpressure();
    int hold = 0;
    int hold_err = 0;
    busy_end = 164;
    start_dump();
    repeat (180) begin
      sample();
      if (s_valid && byte_q.size() == 31 && hold < 3) begin
        hold++;
        if (s_data !== 8'h07) hold_err++;
        drive(1'b0, 1'b0, 1'b0);
      end else begin
        drive(1'b1, 1'b0, 1'b0);
      end
    end
    compared++;
    if (hold != 3 || hold_err != 0) begin
      mismatched++; $display("FAIL bp_hold: got held=%0d bad=%0d required held=3 bad=0", hold, hold_err);
    end
    compared++;
    if (byte_q.size() != 128) begin mismatched++; $display("FAIL bp_count: got %0d required 128", byte_q.size()); end
    for (int j = 0; j < byte_q.size() && j < 128; j++) begin
      compared++;
      if (byte_q[j] !== exp_byte(j)) begin
        mismatched++; $display("FAIL bp_byte[%0d]: got %h required %h", j, byte_q[j], exp_byte(j));
      end
    end
    compared++;
    if (done_cnt != 1 || done_cyc != 164 || busy_err != 0) begin
      mismatched++; $display("FAIL bp_done: got count=%0d cycle=%0d busy_err=%0d required 1/164/0", done_cnt, done_cyc, busy_err);
    end
  endtask

  task automatic test_shadow_capture();
    logic wrote = 1'b0;
    logic [7:0] exp;
    logic [31:0] pat = 32'hDEADBEEF;
    mem[5] = pat;
    busy_end = 161;
    start_dump();
    repeat (175) begin
      sample();
      if (!wrote && s_valid && s_addr == 5'd5) begin mem[5] = 32'h0; wrote = 1'b1; end
      drive(1'b1, 1'b0, 1'b0);
    end
    mem[5] = 32'd5;
    compared++;
    if (!wrote || byte_q.size() != 128) begin
      mismatched++; $display("FAIL shadow_count: got wrote=%b count=%0d required wrote=1 count=128", wrote, byte_q.size());
    end
    for (int j = 16; j < 28 && j < byte_q.size(); j++) begin
      exp = (j >= 20 && j < 24) ? 8'(pat >> (8 * (23 - j))) : exp_byte(j);
      compared++;
      if (byte_q[j] !== exp) begin
        mismatched++; $display("FAIL shadow_byte[%0d]: got %h required %h", j, byte_q[j], exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic pulsed = 1'b0;
    busy_end = 161;
    start_dump();
    repeat (175) begin
      sample();
      if (!pulsed && byte_q.size() == 40) begin drive(1'b1, 1'b1, 1'b0); pulsed = 1'b1; end
      else drive(1'b1, 1'b0, 1'b0);
    end
    compared++;
    if (!pulsed || byte_q.size() != 128 || done_cnt != 1 || done_cyc != 161 || busy_err != 0) begin
      mismatched++;
      $display("FAIL restart_ignored: got pulsed=%b count=%0d done=%0d@%0d busy_err=%0d required 1/128/1@161/0",
               pulsed, byte_q.size(), done_cnt, done_cyc, busy_err);
    end
    compared++;
    if (byte_q.size() > 127 && byte_q[127] !== 8'h1F) begin
      mismatched++; $display("FAIL restart_last: got %h required 1f", byte_q[127]);
    end
  endtask

  task automatic test_abort();
    logic aborted = 1'b0;
    int n = 0;
    busy_end = 1000;
    start_dump();
    while (!aborted && n < 200) begin
      sample();
      n++;
      if (s_valid && s_addr == 5'd10 && byte_q.size() == 41) begin
        drive(1'b1, 1'b0, 1'b1);
        aborted = 1'b1;
      end else begin
        drive(1'b1, 1'b0, 1'b0);
      end
    end
    sample();
    drive(1'b1, 1'b0, 1'b0);
    compared++;
    if (!aborted || s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: got aborted=%b valid=%b busy=%b done=%b required 1/0/0/0", aborted, s_valid, s_busy, s_done);
    end
    repeat (10) begin sample(); drive(1'b1, 1'b0, 1'b0); end
    compared++;
    if (byte_q.size() != 42 || done_cnt != 0) begin
      mismatched++; $display("FAIL abort_bytes: got count=%0d done=%0d required count=42 done=0", byte_q.size(), done_cnt);
    end
    busy_end = 161;
    start_dump();
    repeat (175) begin sample(); drive(1'b1, 1'b0, 1'b0); end
    compared++;
    if (byte_q.size() != 128 || done_cnt != 1 || done_cyc != 161) begin
      mismatched++; $display("FAIL abort_restart: got count=%0d done=%0d@%0d required 128 1@161", byte_q.size(), done_cnt, done_cyc);
    end
    for (int j = 0; j < 8 && j < byte_q.size(); j++) begin
      compared++;
      if (byte_q[j] !== exp_byte(j)) begin
        mismatched++; $display("FAIL abort_byte[%0d]: got %h required %h", j, byte_q[j], exp_byte(j));
      end
    end
  endtask

  task automatic test_async_reset();
    busy_end = 1000;
    start_dump();
    repeat (50) begin sample(); drive(1'b1, 1'b0, 1'b0); end
    @(posedge i_clk);
    #3;
    i_reset = 1'b1;
    #1;
    compared++;
    if ({o_reg_debug_addr, o_tx_valid, o_tx_data, o_busy, o_done} !== 16'h0) begin
      mismatched++;
      $display("FAIL async_reset: got addr=%0d valid=%b data=%h busy=%b done=%b required all 0",
               o_reg_debug_addr, o_tx_valid, o_tx_data, o_busy, o_done);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    busy_end = 161;
    start_dump();
    repeat (175) begin sample(); drive(1'b1, 1'b0, 1'b0); end
    compared++;
    if (byte_q.size() != 128 || done_cnt != 1 || done_cyc != 161 || busy_err != 0) begin
      mismatched++; $display("FAIL reset_dump: got count=%0d done=%0d@%0d busy_err=%0d required 128 1@161 0",
                             byte_q.size(), done_cnt, done_cyc, busy_err);
    end
    for (int j = 0; j < byte_q.size() && j < 128; j++) begin
      compared++;
      if (byte_q[j] !== exp_byte(j)) begin
        mismatched++; $display("FAIL reset_byte[%0d]: got %h required %h", j, byte_q[j], exp_byte(j));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    cyc = 0; done_cnt = 0; done_cyc = -1; busy_err = 0; busy_end = 0;
    s_valid = 1'b0; s_busy = 1'b0; s_done = 1'b0; s_data = 8'h00; s_addr = 5'd0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_shadow_capture();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_dump_sequencer.md
Name: reg_dump_sequencer

Overview:
Debug-unit controller that walks the register file's debug read port from address 0 to TAM-1 and serializes each NB-bit register onto a byte stream for the UART transmitter. It sits between the register file's debug port (address out, data in) and the debug UART TX byte interface. A single start pulse triggers a full dump. The block provides busy and done status, a valid/ready byte handshake and a synchronous abort.

Parameters:
REGS, 5, width of the register address driven to the register file debug port.
NB, 32, register data width; must be a multiple of 8.
TAM, 32, number of registers dumped (addresses 0..TAM-1); TAM <= 2**REGS.

Ports:
i_clk  input  1  system clock, rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_start  input  1  start-dump request; sampled only in IDLE.
i_abort  input  1  synchronous abort; returns the block to IDLE.
o_reg_debug_addr  output  REGS  address to the register file debug read port.
i_reg_debug_data  input  NB  combinational read data from the register file debug port.
o_tx_valid  output  1  byte available on o_tx_data.
o_tx_data  output  8  byte to the UART TX.
i_tx_ready  input  1  UART TX accepts the byte this cycle.
o_busy  output  1  high in every state except IDLE.
o_done  output  1  one-cycle pulse when the last byte has been accepted.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, o_reg_debug_addr=0, shadow register=0, byte index=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0.
- State machine states: IDLE, LATCH, SEND, DONE. All outputs are registered or decoded from state and registers; there is no combinational path from i_tx_ready to any output.
- IDLE:
  - i_start=1 → o_reg_debug_addr<=0, go to LATCH.
  - i_start=0 → stay in IDLE.
- LATCH (1 cycle): shadow <= i_reg_debug_data, byte index <= 0, go to SEND.
  - Data is captured in this cycle. Writes to the register file after this cycle do not affect the bytes sent for this register.
- SEND:
  - o_tx_valid=1.
  - o_tx_data = shadow byte [NB-1-8*idx : NB-8-8*idx], so bytes go out MSB-first.
  - While i_tx_ready=0, o_tx_valid and o_tx_data hold stable.
  - On o_tx_valid & i_tx_ready, one byte is transferred, then:
    - idx < NB/8-1 → idx++.
    - idx = NB/8-1 and addr < TAM-1 → addr++, go to LATCH.
    - idx = NB/8-1 and addr = TAM-1 → go to DONE.
- DONE (1 cycle): o_done=1, go to IDLE. o_reg_debug_addr keeps its last value (TAM-1) until the next start.
- Outside SEND: o_tx_valid=0 and o_tx_data=0.
- Latency with i_tx_ready held high: 1 + TAM*(1 + NB/8) cycles from the start-sampling edge to o_done. With the defaults this is 161 cycles, and each register takes 5 cycles.
- i_start in any state other than IDLE is ignored. The block does not queue a second dump.
- i_abort (any non-IDLE state) takes priority over every other transition:
  - Next state is IDLE, o_tx_valid drops on the next cycle and o_done is not pulsed.
  - The byte whose handshake completes in the abort cycle counts as sent.
  - i_abort in IDLE has no effect. If i_abort and i_start are both high in IDLE, the start is taken.
- Address and index counters never exceed TAM-1 and NB/8-1; there is no wrap-around inside a dump.

Test Plan:
1. Register file model memory[i]=i, i_tx_ready=1, pulse i_start → 128 bytes: 00 00 00 00, 00 00 00 01, … 00 00 00 1F; o_done is a single pulse exactly 161 cycles after the start cycle; o_busy is high for cycles 1..161.
2. Backpressure: drop i_tx_ready for 3 cycles while the byte 00 00 00 07's last byte (0x07) is pending → o_tx_valid=1 and o_tx_data=0x07 are held for all 3 cycles; no byte is duplicated or dropped; total byte count is 128.
3. Set memory[5]=0xDEADBEEF, then change it to 0 one cycle after LATCH for addr 5 → bytes DE AD BE EF are sent for register 5.
4. Pulse i_start again at byte 40 → ignored; exactly 128 bytes and one o_done.
5. i_abort during SEND of register 10 → next cycle IDLE, o_tx_valid=0, o_busy=0, no o_done; a following i_start restarts at address 0.
6. Assert i_reset asynchronously mid-byte (between clock edges) → all outputs go to 0 immediately; after reset, i_start yields a full, correct 128-byte dump.
